fifo_n_base: RTL and testbench

FIFO_N_BASE -- requirements
Module: fifo_n_base

---
 rtl/fifo_n_base.sv | 129 ++++++++++++
 tb/tb_fifo_n_base.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_n_base.sv
// fifo_n_base
// -----------
// Parameterised register-array FIFO with three flow-control flavours:
//   MODE 0  normal   : plain FIFO, one cycle enqueue-to-dequeue latency.
//   MODE 1  bypass   : when empty, an enqueue can be consumed in the same
//                      cycle through a combinational path (no storage used).
//   MODE 2  pipeline : when full, an enqueue is accepted if a dequeue fires
//                      in the same cycle, so a full FIFO can still stream.
//
// Ports
//   CLK            sole clock, rising edge
//   RST            synchronous, active-high reset
//   in_enq_ena     enqueue request (legal only while in_enq_rdy=1)
//   in_enq_v       enqueue data
//   in_enq_rdy     enqueue guard
//   out_deq_ena    dequeue request (legal only while out_deq_rdy=1)
//   out_deq_rdy    dequeue guard
//   out_first      head-of-queue data
//   out_first_rdy  out_first guard, identical to out_deq_rdy
//   count          registered occupancy, 0..DEPTH
//
// Handshake: a transfer on either side happens at a rising edge exactly
// when its ENA and its RDY are both 1 during the preceding cycle. RDY
// never depends on its own ENA. Any ENA presented while its RDY is 0 is
// ignored and leaves the state untouched. Enqueue and dequeue are
// independent and may both fire in the same cycle.

module fifo_n_base #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_enq_ena,
  input  logic [WIDTH-1:0]           in_enq_v,
  output logic                       in_enq_rdy,
  input  logic                       out_deq_ena,
  output logic                       out_deq_rdy,
  output logic [WIDTH-1:0]           out_first,
  output logic                       out_first_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam bit BYPASS = (MODE == 1);
  localparam bit PIPE   = (MODE == 2);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic full;
  logic empty;
  logic enq_rdy;
  logic deq_rdy;
  logic enq_fire;
  logic deq_fire;
  logic pass_thru;

  // Guards and head data
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);

    // Both guards are forced low while reset is held so that any ENA
    // arriving in a reset cycle cannot fire.
    enq_rdy = !RST && (!full || (PIPE && out_deq_ena));
    deq_rdy = !RST && (!empty || (BYPASS && in_enq_ena));

    enq_fire = in_enq_ena && enq_rdy;
    deq_fire = out_deq_ena && deq_rdy;

    // Bypass on an empty queue: the value is handed straight to the
    // consumer and never touches the array, pointers or count.
    pass_thru = BYPASS && empty && enq_fire && deq_fire;

    in_enq_rdy    = enq_rdy;
    out_deq_rdy   = deq_rdy;
    out_first_rdy = deq_rdy;
    out_first     = (BYPASS && empty) ? in_enq_v : mem_q[rd_ptr_q];
    count         = count_q;
  end

  // Next-state computation
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (!pass_thru) begin
      if (enq_fire) begin
        mem_d[wr_ptr_q] = in_enq_v;
        // DEPTH is a power of two, so the pointer wraps by overflow.
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: pointers and occupancy are reset, storage is not.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fifo_n_base.sv
module tb_fifo_n_base;

  logic CLK = 1'b0;
  logic RST;

  // One DUT per MODE (index = MODE), all WIDTH=8, DEPTH=4.
  logic [2:0]      enq_ena;
  logic [2:0][7:0] enq_v;
  logic [2:0]      deq_ena;
  wire  [2:0]      enq_rdy;
  wire  [2:0]      deq_rdy;
  wire  [2:0]      first_rdy;
  wire  [2:0][7:0] first;
  wire  [2:0][2:0] cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit proto_chk = 1'b1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fifo_n_base #(.WIDTH(8), .DEPTH(4), .MODE(g)) u_dut (
      .CLK           (CLK),
      .RST           (RST),
      .in_enq_ena    (enq_ena[g]),
      .in_enq_v      (enq_v[g]),
      .in_enq_rdy    (enq_rdy[g]),
      .out_deq_ena   (deq_ena[g]),
      .out_deq_rdy   (deq_rdy[g]),
      .out_first     (first[g]),
      .out_first_rdy (first_rdy[g]),
      .count         (cnt[g])
    );
  end

  // Clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Protocol watch: an ENA with its RDY low must never be presented,
  // except inside the test that deliberately does so.
  always @(posedge CLK) begin
    if (proto_chk && !RST) begin
      for (int m = 0; m < 3; m++) begin
        assert (!(enq_ena[m] && !enq_rdy[m]))
          else $error("FAIL protocol_enq m%0d: got ENA=1 RDY=0 want no ENA", m);
        assert (!(deq_ena[m] && !deq_rdy[m]))
          else $error("FAIL protocol_deq m%0d: got ENA=1 RDY=0 want no ENA", m);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all();
    enq_ena = '0;
    deq_ena = '0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    RST = 1'b1;
    idle_all();
    enq_v = '0;
    enq_ena[1] = 1'b1;
    enq_v[1] = 8'h5A;
    tick();
    tick();
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if (enq_rdy[m] !== 1'b0) begin
        n_fail++; $display("FAIL reset_enq_rdy m%0d: got %b want 0", m, enq_rdy[m]);
      end
      n_checks++;
      if (deq_rdy[m] !== 1'b0) begin
        n_fail++; $display("FAIL reset_deq_rdy m%0d: got %b want 0", m, deq_rdy[m]);
      end
      n_checks++;
      if (first_rdy[m] !== 1'b0) begin
        n_fail++; $display("FAIL reset_first_rdy m%0d: got %b want 0", m, first_rdy[m]);
      end
      n_checks++;
      if (cnt[m] !== 3'd0) begin
        n_fail++; $display("FAIL reset_count m%0d: got %0d want 0", m, cnt[m]);
      end
    end
    RST = 1'b0;
    enq_ena = '0;
    #1;
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if (enq_rdy[m] !== 1'b1) begin
        n_fail++; $display("FAIL post_reset_enq_rdy m%0d: got %b want 1", m, enq_rdy[m]);
      end
      n_checks++;
      if (deq_rdy[m] !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_deq_rdy m%0d: got %b want 0", m, deq_rdy[m]);
      end
      n_checks++;
      if (cnt[m] !== 3'd0) begin
        n_fail++; $display("FAIL post_reset_count m%0d: got %0d want 0", m, cnt[m]);
      end
    end
    // Bypass: dequeue guard follows the enqueue request when empty.
    enq_ena[1] = 1'b1;
    #1;
    n_checks++;
    if (deq_rdy[1] !== 1'b1 || first_rdy[1] !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_bypass_rdy: got %b/%b want 1/1", deq_rdy[1], first_rdy[1]);
    end
    n_checks++;
    if (first[1] !== 8'h5A) begin
      n_fail++; $display("FAIL post_reset_bypass_first: got %h want 5a", first[1]);
    end
    enq_ena[1] = 1'b0;
    #1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      enq_ena[0] = 1'b1;
      enq_v[0] = vals[i];
      #1;
      if (i == 0) begin
        n_checks++;
        if (deq_rdy[0] !== 1'b0) begin
          n_fail++; $display("FAIL fill_latency: got deq_rdy %b want 0", deq_rdy[0]);
        end
      end
      n_checks++;
      if (enq_rdy[0] !== 1'b1) begin
        n_fail++; $display("FAIL fill_enq_rdy i%0d: got %b want 1", i, enq_rdy[0]);
      end
      tick();
    end
    enq_ena[0] = 1'b0;
    #1;
    n_checks++;
    if (cnt[0] !== 3'd4 || enq_rdy[0] !== 1'b0 || deq_rdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full: got count %0d enq_rdy %b deq_rdy %b want 4 0 1", cnt[0], enq_rdy[0], deq_rdy[0]);
    end
    for (int i = 0; i < 4; i++) begin
      deq_ena[0] = 1'b1;
      #1;
      n_checks++;
      if (first[0] !== vals[i]) begin
        n_fail++; $display("FAIL drain_first i%0d: got %h want %h", i, first[0], vals[i]);
      end
      tick();
    end
    deq_ena[0] = 1'b0;
    #1;
    n_checks++;
    if (cnt[0] !== 3'd0 || deq_rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got count %0d deq_rdy %b want 0 0", cnt[0], deq_rdy[0]);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    for (int i = 0; i < 2; i++) begin
      enq_ena[0] = 1'b1;
      enq_v[0] = 8'hA0 + 8'(i);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      enq_ena[0] = 1'b1;
      enq_v[0] = 8'(i);
      deq_ena[0] = 1'b1;
      #1;
      exp = (i < 2) ? 8'hA0 + 8'(i) : 8'(i - 2);
      n_checks++;
      if (first[0] !== exp) begin
        n_fail++; $display("FAIL wrap_first i%0d: got %h want %h", i, first[0], exp);
      end
      tick();
      n_checks++;
      if (cnt[0] !== 3'd2) begin
        n_fail++; $display("FAIL wrap_count i%0d: got %0d want 2", i, cnt[0]);
      end
    end
    enq_ena[0] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      deq_ena[0] = 1'b1;
      #1;
      n_checks++;
      if (first[0] !== 8'(8 + j)) begin
        n_fail++; $display("FAIL wrap_tail j%0d: got %h want %h", j, first[0], 8'(8 + j));
      end
      tick();
    end
    deq_ena[0] = 1'b0;
    #1;
    n_checks++;
    if (cnt[0] !== 3'd0) begin
      n_fail++; $display("FAIL wrap_end_count: got %0d want 0", cnt[0]);
    end
  endtask

  task automatic test_bypass();
    enq_ena[1] = 1'b1;
    enq_v[1] = 8'hA5;
    #1;
    n_checks++;
    if (deq_rdy[1] !== 1'b1 || enq_rdy[1] !== 1'b1) begin
      n_fail++; $display("FAIL bypass_rdy: got deq %b enq %b want 1 1", deq_rdy[1], enq_rdy[1]);
    end
    deq_ena[1] = 1'b1;
    #1;
    n_checks++;
    if (first[1] !== 8'hA5) begin
      n_fail++; $display("FAIL bypass_first: got %h want a5", first[1]);
    end
    tick();
    idle_all();
    #1;
    n_checks++;
    if (cnt[1] !== 3'd0 || deq_rdy[1] !== 1'b0) begin
      n_fail++; $display("FAIL bypass_after: got count %0d deq_rdy %b want 0 0", cnt[1], deq_rdy[1]);
    end
    // A plain enqueue then lands in storage normally.
    enq_ena[1] = 1'b1;
    enq_v[1] = 8'h3C;
    tick();
    enq_ena[1] = 1'b0;
    #1;
    n_checks++;
    if (cnt[1] !== 3'd1 || first[1] !== 8'h3C) begin
      n_fail++; $display("FAIL bypass_store: got count %0d first %h want 1 3c", cnt[1], first[1]);
    end
    // Non-empty: head is the stored entry, not the incoming one.
    enq_ena[1] = 1'b1;
    enq_v[1] = 8'h77;
    deq_ena[1] = 1'b1;
    #1;
    n_checks++;
    if (first[1] !== 8'h3C) begin
      n_fail++; $display("FAIL bypass_nonempty_first: got %h want 3c", first[1]);
    end
    tick();
    enq_ena[1] = 1'b0;
    #1;
    n_checks++;
    if (cnt[1] !== 3'd1 || first[1] !== 8'h77) begin
      n_fail++; $display("FAIL bypass_nonempty_after: got count %0d first %h want 1 77", cnt[1], first[1]);
    end
    tick();
    deq_ena[1] = 1'b0;
    #1;
    n_checks++;
    if (cnt[1] !== 3'd0) begin
      n_fail++; $display("FAIL bypass_drain: got count %0d want 0", cnt[1]);
    end
  endtask

  task automatic test_pipeline_full();
    logic [7:0] exp [4];
    exp = '{8'h02, 8'h03, 8'h04, 8'h55};
    for (int i = 0; i < 4; i++) begin
      enq_ena[2] = 1'b1;
      enq_v[2] = 8'(i + 1);
      tick();
    end
    enq_ena[2] = 1'b0;
    #1;
    n_checks++;
    if (cnt[2] !== 3'd4 || enq_rdy[2] !== 1'b0) begin
      n_fail++; $display("FAIL pipe_full: got count %0d enq_rdy %b want 4 0", cnt[2], enq_rdy[2]);
    end
    deq_ena[2] = 1'b1;
    #1;
    n_checks++;
    if (enq_rdy[2] !== 1'b1 || first[2] !== 8'h01) begin
      n_fail++; $display("FAIL pipe_enq_rdy: got enq_rdy %b first %h want 1 01", enq_rdy[2], first[2]);
    end
    enq_ena[2] = 1'b1;
    enq_v[2] = 8'h55;
    tick();
    enq_ena[2] = 1'b0;
    deq_ena[2] = 1'b0;
    #1;
    n_checks++;
    if (cnt[2] !== 3'd4) begin
      n_fail++; $display("FAIL pipe_count: got %0d want 4", cnt[2]);
    end
    for (int i = 0; i < 4; i++) begin
      deq_ena[2] = 1'b1;
      #1;
      n_checks++;
      if (first[2] !== exp[i]) begin
        n_fail++; $display("FAIL pipe_order i%0d: got %h want %h", i, first[2], exp[i]);
      end
      tick();
    end
    deq_ena[2] = 1'b0;
    #1;
    n_checks++;
    if (cnt[2] !== 3'd0) begin
      n_fail++; $display("FAIL pipe_drain: got %0d want 0", cnt[2]);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      enq_ena[0] = 1'b1;
      enq_ena[2] = 1'b1;
      enq_v[0] = 8'(i + 1);
      enq_v[2] = 8'(i + 1);
      tick();
    end
    #1;
    n_checks++;
    if (cnt[0] !== 3'd3 || cnt[2] !== 3'd3) begin
      n_fail++; $display("FAIL mid_pre_count: got %0d/%0d want 3/3", cnt[0], cnt[2]);
    end
    RST = 1'b1;
    enq_v[0] = 8'h99;
    enq_v[2] = 8'h99;
    tick();
    RST = 1'b0;
    idle_all();
    #1;
    for (int m = 0; m < 3; m += 2) begin
      n_checks++;
      if (cnt[m] !== 3'd0 || deq_rdy[m] !== 1'b0 || enq_rdy[m] !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_reset m%0d: got count %0d deq_rdy %b enq_rdy %b want 0 0 1", m, cnt[m], deq_rdy[m], enq_rdy[m]);
      end
    end
  endtask

  task automatic test_protocol_ignore();
    proto_chk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq_ena[0] = 1'b1;
      enq_v[0] = 8'hC1 + 8'(i);
      tick();
    end
    enq_v[0] = 8'hEE;
    tick();
    enq_ena[0] = 1'b0;
    #1;
    n_checks++;
    if (cnt[0] !== 3'd4) begin
      n_fail++; $display("FAIL ignore_enq_count: got %0d want 4", cnt[0]);
    end
    for (int i = 0; i < 4; i++) begin
      deq_ena[0] = 1'b1;
      #1;
      n_checks++;
      if (first[0] !== 8'hC1 + 8'(i)) begin
        n_fail++; $display("FAIL ignore_order i%0d: got %h want %h", i, first[0], 8'hC1 + 8'(i));
      end
      tick();
    end
    tick();
    deq_ena[0] = 1'b0;
    #1;
    n_checks++;
    if (cnt[0] !== 3'd0 || deq_rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL ignore_deq_empty: got count %0d deq_rdy %b want 0 0", cnt[0], deq_rdy[0]);
    end
    proto_chk = 1'b1;
    enq_ena[0] = 1'b1;
    enq_v[0] = 8'h12;
    tick();
    enq_ena[0] = 1'b0;
    #1;
    n_checks++;
    if (cnt[0] !== 3'd1 || first[0] !== 8'h12) begin
      n_fail++; $display("FAIL ignore_recover: got count %0d first %h want 1 12", cnt[0], first[0]);
    end
    deq_ena[0] = 1'b1;
    tick();
    deq_ena[0] = 1'b0;
    #1;
  endtask

  task automatic test_random(input int m);
    logic [7:0] exp_q [$];
    logic [7:0] v;
    logic [7:0] exp_first;
    logic       exp_enq_rdy;
    logic       exp_deq_rdy;
    int         sz;
    for (int c = 0; c < 10000; c++) begin
      v = 8'($urandom_range(0, 255));
      enq_v[m] = v;
      enq_ena[m] = 1'($urandom_range(0, 1));
      deq_ena[m] = 1'($urandom_range(0, 1));
      #1;
      if (enq_ena[m] && !enq_rdy[m]) enq_ena[m] = 1'b0;
      #1;
      if (deq_ena[m] && !deq_rdy[m]) deq_ena[m] = 1'b0;
      #1;
      sz = exp_q.size();
      exp_enq_rdy = (sz < 4) || (m == 2 && deq_ena[m]);
      exp_deq_rdy = (sz > 0) || (m == 1 && enq_ena[m]);
      n_checks++;
      if (enq_rdy[m] !== exp_enq_rdy || deq_rdy[m] !== exp_deq_rdy) begin
        n_fail++;
        $display("FAIL rand_rdy m%0d c%0d: got %b%b want %b%b", m, c, enq_rdy[m], deq_rdy[m], exp_enq_rdy, exp_deq_rdy);
      end
      if (deq_ena[m]) begin
        exp_first = (sz == 0) ? v : exp_q[0];
        n_checks++;
        if (first[m] !== exp_first) begin
          n_fail++; $display("FAIL rand_first m%0d c%0d: got %h want %h", m, c, first[m], exp_first);
        end
      end
      if (!(m == 1 && sz == 0 && enq_ena[m] && deq_ena[m])) begin
        if (enq_ena[m]) exp_q.push_back(v);
        if (deq_ena[m]) void'(exp_q.pop_front());
      end
      tick();
      n_checks++;
      if (int'(cnt[m]) != exp_q.size()) begin
        n_fail++; $display("FAIL rand_count m%0d c%0d: got %0d want %0d", m, c, cnt[m], exp_q.size());
      end
    end
    enq_ena[m] = 1'b0;
    deq_ena[m] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_bypass();
    test_pipeline_full();
    test_reset_mid();
    test_protocol_ignore();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
